// File: rtl/touch_spi_pkg.sv
// Shared types and XPT2046 command bytes for the touch SPI scanner.
package touch_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_TURN = 3'd2,
    ST_READ = 3'd3,
    ST_TAIL = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  localparam logic [7:0] CMD_X  = 8'hD0;
  localparam logic [7:0] CMD_Y  = 8'h90;
  localparam logic [7:0] CMD_Z1 = 8'hB0;
  localparam logic [7:0] CMD_Z2 = 8'hC0;

endpackage

// File: rtl/touch_sck_gen.sv
// SCK half-period counter; emits one-cycle rise/fall strobes while run is high.
module touch_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck_rise,
  output logic sck_fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       strobe_s;

  always_comb begin
    strobe_s = run && (cnt_q == DIV_LAST);
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (!run) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (strobe_s) begin
      cnt_d   = 8'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 8'd1;
    end
    sck_rise = strobe_s && !phase_q;
    sck_fall = strobe_s && phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/touch_spi_scanner.sv
// XPT2046-style touch controller SPI scanner (manual frames plus pen-down auto scan).
// Optional build macro TOUCH_IRQ_DEBOUNCE_EN adds a pen-down debounce counter.
module touch_spi_scanner
  import touch_spi_pkg::*;
#(
  parameter int                    CMD_W     = 8,
  parameter int                    RESP_W    = 12,
  parameter int                    TAIL_W    = 3,
  parameter int                    CLK_DIV   = 2,
  parameter int                    N_CH      = 4,
  parameter logic [N_CH*CMD_W-1:0] CMD_TABLE = {CMD_Z2, CMD_Z1, CMD_Y, CMD_X},
  parameter int                    CS_GAP    = 4
`ifdef TOUCH_IRQ_DEBOUNCE_EN
  ,
  parameter int                    DEBOUNCE_CYC = 16
`endif
) (
  input  logic                                         clk_1MHz,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic [CMD_W-1:0]                             data_in,
  input  logic                                         scan_en,
  input  logic                                         i_sdo,
  input  logic                                         i_irq,
  output logic                                         busy,
  output logic [RESP_W-1:0]                            data_out,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   ch_id,
  output logic                                         data_valid,
  output logic                                         frame_done,
  output logic                                         o_cs,
  output logic                                         o_sdi,
  output logic                                         o_sck
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int P_TOT = CMD_W + 1 + RESP_W + TAIL_W;
  localparam int PER_W = $clog2(P_TOT + 1);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [PER_W-1:0] PER_ZERO     = PER_W'(0);
  localparam logic [PER_W-1:0] PER_ONE      = PER_W'(1);
  localparam logic [PER_W-1:0] PER_CMD_END  = PER_W'(CMD_W);
  localparam logic [PER_W-1:0] PER_TURN_END = PER_W'(CMD_W + 1);
  localparam logic [PER_W-1:0] PER_READ_END = PER_W'(CMD_W + 1 + RESP_W);
  localparam logic [PER_W-1:0] PER_DONE     = PER_W'(P_TOT);
  localparam logic [GAP_W-1:0] GAP_ZERO     = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE      = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(CS_GAP - 1);
  localparam logic [CH_W-1:0]  CH_ZERO      = CH_W'(0);
  localparam logic [CH_W-1:0]  CH_ONE       = CH_W'(1);
  localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(N_CH - 1);

  state_e              state_q, state_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [CMD_W-1:0]    cmd_sh_q, cmd_sh_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
  logic                manual_q, manual_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic [RESP_W-1:0]   data_out_q, data_out_d;
  logic [CH_W-1:0]     ch_id_q, ch_id_d;
  logic                dv_q, dv_d;
  logic                fd_q, fd_d;
  logic                irq_s1_q, irq_s2_q;

  logic                run_s;
  logic                sck_rise_s, sck_fall_s;
  logic                pen_down_s;
  logic                scan_req_s;
  logic [CMD_W-1:0]    cmd_sel_s;

  assign run_s = (state_q == ST_CMD) || (state_q == ST_TURN) ||
                 (state_q == ST_READ) || (state_q == ST_TAIL);

  touch_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk_1MHz),
    .rst      (rst),
    .run      (run_s),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s)
  );

  // The pen IRQ is asynchronous to clk_1MHz; idle level is high (pen up).
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      irq_s1_q <= 1'b1;
      irq_s2_q <= 1'b1;
    end else begin
      irq_s1_q <= i_irq;
      irq_s2_q <= irq_s1_q;
    end
  end

`ifdef TOUCH_IRQ_DEBOUNCE_EN
  localparam int              DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Count only in IDLE so a qualified pen-down survives across back-to-back frames.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (state_q == ST_IDLE) begin
      if (irq_s2_q) begin
        db_cnt_d = DB_W'(0);
      end else if (db_cnt_q != DB_MAX) begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end else begin
        db_cnt_d = db_cnt_q;
      end
    end else begin
      db_cnt_d = db_cnt_q;
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      db_cnt_q <= DB_W'(0);
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end

  assign pen_down_s = (db_cnt_q == DB_MAX);
`else
  assign pen_down_s = ~irq_s2_q;
`endif

  assign scan_req_s = scan_en && pen_down_s;
  assign cmd_sel_s  = CMD_TABLE[int'(ch_idx_q) * CMD_W +: CMD_W];

  always_comb begin
    state_d    = state_q;
    per_d      = per_q;
    cmd_sh_d   = cmd_sh_q;
    resp_d     = resp_q;
    gap_d      = gap_q;
    ch_idx_d   = ch_idx_q;
    manual_d   = manual_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    sdi_d      = sdi_q;
    data_out_d = data_out_q;
    ch_id_d    = ch_id_q;
    dv_d       = 1'b0;
    fd_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en || scan_req_s) begin
          state_d  = ST_CMD;
          cs_d     = 1'b0;
          per_d    = PER_ZERO;
          resp_d   = {RESP_W{1'b0}};
          manual_d = en;
          cmd_sh_d = en ? data_in : cmd_sel_s;
          sdi_d    = cmd_sh_d[CMD_W-1];
        end else begin
          state_d  = ST_IDLE;
        end
        // Leaving the pen-down scan at an inter-frame IDLE abandons it.
        if (!scan_req_s) begin
          ch_idx_d = CH_ZERO;
        end else begin
          ch_idx_d = ch_idx_q;
        end
      end

      ST_CMD, ST_TURN, ST_READ, ST_TAIL: begin
        if (sck_rise_s) begin
          if (per_q == PER_DONE) begin
            // The would-be next rising edge becomes the CS release point.
            state_d    = ST_GAP;
            cs_d       = 1'b1;
            sdi_d      = 1'b0;
            gap_d      = GAP_ZERO;
            dv_d       = 1'b1;
            data_out_d = resp_q;
            if (manual_q) begin
              ch_id_d = CH_ZERO;
            end else begin
              ch_id_d = ch_idx_q;
              if (ch_idx_q == CH_LAST) begin
                fd_d     = 1'b1;
                ch_idx_d = CH_ZERO;
              end else begin
                ch_idx_d = ch_idx_q + CH_ONE;
              end
            end
          end else begin
            sck_d = 1'b1;
            if (state_q == ST_READ) begin
              resp_d = {resp_q[RESP_W-2:0], i_sdo};
            end else begin
              resp_d = resp_q;
            end
          end
        end else if (sck_fall_s) begin
          sck_d    = 1'b0;
          per_d    = per_q + PER_ONE;
          cmd_sh_d = cmd_sh_q << 1;
          sdi_d    = cmd_sh_d[CMD_W-1];
          if (per_d == PER_CMD_END) begin
            state_d = ST_TURN;
          end else if (per_d == PER_TURN_END) begin
            state_d = ST_READ;
          end else if (per_d == PER_READ_END) begin
            state_d = ST_TAIL;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        sdi_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      per_q      <= PER_ZERO;
      cmd_sh_q   <= {CMD_W{1'b0}};
      resp_q     <= {RESP_W{1'b0}};
      gap_q      <= GAP_ZERO;
      ch_idx_q   <= CH_ZERO;
      manual_q   <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      data_out_q <= {RESP_W{1'b0}};
      ch_id_q    <= CH_ZERO;
      dv_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      cmd_sh_q   <= cmd_sh_d;
      resp_q     <= resp_d;
      gap_q      <= gap_d;
      ch_idx_q   <= ch_idx_d;
      manual_q   <= manual_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      data_out_q <= data_out_d;
      ch_id_q    <= ch_id_d;
      dv_q       <= dv_d;
      fd_q       <= fd_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign ch_id      = ch_id_q;
  assign data_valid = dv_q;
  assign frame_done = fd_q;
  assign o_cs       = cs_q;
  assign o_sck      = sck_q;
  assign o_sdi      = sdi_q;

endmodule
